// File: rtl/x1dn_pipe_pkg.sv
// x1dn_pipe_pkg: action encodings, kill pattern and flag vote helper shared by the pipe.
package x1dn_pipe_pkg;
    typedef enum logic [1:0] {
        ACT_PASS = 2'b00,
        ACT_INV  = 2'b01,
        ACT_ZERO = 2'b10,
        ACT_HOLD = 2'b11
    } act_e;
    localparam logic [1:0] KILL_ALL = 2'b11;
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/x1dn_pipe_fifo.sv
// x1dn_pipe_fifo: show-ahead FIFO with power-of-2 depth and an occupancy count.
module x1dn_pipe_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    assign o_data  = r_mem[r_rd];
    assign o_valid = r_count != '0;
    assign o_count = r_count;
endmodule

// File: rtl/x1dn_pipe.sv
// x1dn_pipe: channel select + action/majority stage feeding a show-ahead output FIFO.
module x1dn_pipe
    import x1dn_pipe_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic [$clog2(NCH)-1:0]   in_sel,
    input  logic [NCH*DW-1:0]        in_data,
    input  logic [1:0]               in_kill,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_flag,
    output logic [7:0]               drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          r_s1_valid;
    logic [DW-1:0] r_s1_data;
    logic          r_s1_flag;
    logic [DW-1:0] r_last;
    logic [7:0]    r_drop;
    logic [DW-1:0] w_ch;
    logic [DW-1:0] w_data;
    logic          w_acc;
    logic          w_kill;
    logic          w_fifo_valid;
    logic [CW-1:0] w_count;
    logic [DW:0]   w_head;
    act_e          w_act;
    assign w_ch   = in_data[in_sel*DW +: DW];
    assign w_act  = act_e'(in_op[4:3]);
    assign w_kill = in_kill == KILL_ALL;
    always_comb begin
        w_data = (w_act == ACT_PASS) ? w_ch :
                 (w_act == ACT_INV)  ? ~w_ch :
                 (w_act == ACT_ZERO) ? '0 : r_last;
    end
    // Stage 1 counts against capacity so its next-cycle push can never overflow.
    assign in_ready = rst_n && ((w_count + CW'(r_s1_valid)) < CW'(DEPTH));
    assign w_acc    = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_last     <= '0;
            r_drop     <= '0;
        end else begin
            r_s1_valid <= w_acc && !w_kill;
            if (w_acc && !w_kill) r_last <= w_data;
            if (w_acc && w_kill && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_acc && !w_kill) begin
            r_s1_data <= w_data;
            r_s1_flag <= maj3(in_op[2:0]);
        end
    end
    x1dn_pipe_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s1_valid),
        .i_pop   (out_valid && out_ready),
        .i_data  ({r_s1_data, r_s1_flag}),
        .o_data  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );
    assign out_valid            = rst_n && w_fifo_valid;
    assign {out_data, out_flag} = w_head;
    assign drop_cnt             = r_drop;
endmodule
